// File: rtl/simd_shift_sequencer.sv
// Multi-cycle per-lane SIMD shifter. It applies one 1-bit shift per cycle to every lane.
// The request handshake is IDLE -> SHIFT -> DONE, and the result is held until the consumer accepts it.
module simd_shift_sequencer #(
  parameter int unsigned LANE_W = 4,
  parameter int unsigned LANES  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   in_data,
  input  logic [1:0]                in_mode,
  input  logic [1:0]                in_amt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_data,
  output logic                      busy
);

  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam int unsigned AMT_W  = 2;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_SLL  = 2'b01;
  localparam logic [1:0] MODE_SRL  = 2'b10;
  localparam logic [1:0] MODE_SRA  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [AMT_W-1:0]    count;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   work;
  logic [DATA_W-1:0]   work_step;
  logic                accept;
  logic                direct;

  assign accept = in_valid && (state == IDLE);
  assign direct = (in_mode == MODE_PASS) || (in_amt == AMT_W'(0));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = direct ? DONE : SHIFT;
      SHIFT:   if (count == AMT_W'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode of the registered state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // One 1-bit shift per lane; the shifted-out bit never crosses a lane boundary
  always_comb begin
    work_step = work;
    for (int i = 0; i < int'(LANES); i++) begin
      case (mode_q)
        MODE_SLL: work_step[i*LANE_W +: LANE_W] = {work[i*LANE_W +: LANE_W-1], 1'b0};
        MODE_SRL: work_step[i*LANE_W +: LANE_W] = {1'b0, work[i*LANE_W+1 +: LANE_W-1]};
        MODE_SRA: work_step[i*LANE_W +: LANE_W] =
                    {work[i*LANE_W+LANE_W-1], work[i*LANE_W+1 +: LANE_W-1]};
        default:  work_step[i*LANE_W +: LANE_W] = work[i*LANE_W +: LANE_W];
      endcase
    end
  end

  // Working register, shift count and captured mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work   <= '0;
      count  <= '0;
      mode_q <= MODE_PASS;
    end else begin
      case (state)
        IDLE: if (accept) begin
          work   <= in_data;
          mode_q <= in_mode;
          count  <= direct ? AMT_W'(0) : in_amt;
        end
        SHIFT: begin
          work  <= work_step;
          count <= count - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = work;

endmodule

// File: tb/tb_simd_shift_sequencer.sv
// Directed self-checking bench for simd_shift_sequencer: it checks the shift results, latency, backpressure and reset abort.
module tb_simd_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [1:0]  in_mode;
  logic [1:0]  in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  simd_shift_sequencer #(.LANE_W(4), .LANES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure latency to out_valid, check the result, then retire it
  task automatic run_req(input string tag, input logic [63:0] data, input logic [1:0] mode,
                         input logic [1:0] amt, input logic [63:0] exp, input int exp_lat);
    int lat;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    in_amt   = amt;
    tick();
    in_valid = 1'b0;
    in_data  = ~data;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_retire"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  logic [63:0] held;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    in_amt    = '0;
    out_ready = 1'b0;
    #12;
    check("reset_outputs", {60'd0, in_ready, out_valid, busy, 1'b0}, 64'b1000);
    check("reset_data", out_data, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_req("srl1",    64'h0123456789ABCDEF, 2'b10, 2'd1, 64'h0011223344556677, 2);
    run_req("sll2",    64'h7777777777777777, 2'b01, 2'd2, 64'hCCCCCCCCCCCCCCCC, 3);
    run_req("sra3neg", 64'h9999999999999999, 2'b11, 2'd3, 64'hFFFFFFFFFFFFFFFF, 4);
    run_req("sra1",    64'h9999999999999999, 2'b11, 2'd1, 64'hCCCCCCCCCCCCCCCC, 2);
    run_req("pass3",   64'hDEADBEEF00C0FFEE, 2'b00, 2'd3, 64'hDEADBEEF00C0FFEE, 1);
    run_req("sll0",    64'hDEADBEEF00C0FFEE, 2'b01, 2'd0, 64'hDEADBEEF00C0FFEE, 1);
    run_req("sra3pos", 64'h7777777777777777, 2'b11, 2'd3, 64'h0000000000000000, 4);
    run_req("sra2mix", 64'h0123456789ABCDEF, 2'b11, 2'd2, 64'h00001111EEEEFFFF, 3);
    run_req("srl3",    64'hFFFFFFFFFFFFFFFF, 2'b10, 2'd3, 64'h1111111111111111, 4);
    run_req("sll3",    64'hFFFFFFFFFFFFFFFF, 2'b01, 2'd3, 64'h8888888888888888, 4);

    // Backpressure: the result is held while new requests are ignored
    in_valid = 1'b1;
    in_data  = 64'h0123456789ABCDEF;
    in_mode  = 2'b10;
    in_amt   = 2'd1;
    tick();
    tick();
    check("bp_valid", 64'(out_valid), 64'd1);
    held = 64'h0011223344556677;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = {$urandom, $urandom};
      in_mode  = 2'(i);
      in_amt   = 2'(i + 1);
      tick();
      check("bp_hold_data", out_data, held);
      check("bp_flags", {61'd0, in_ready, out_valid, busy}, 64'b011);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {62'd0, in_ready, out_valid}, 64'b10);

    // Asynchronous reset in the middle of SHIFT aborts the transaction
    in_valid = 1'b1;
    in_data  = 64'h9999999999999999;
    in_mode  = 2'b11;
    in_amt   = 2'd3;
    tick();
    in_valid = 1'b0;
    tick();
    check("abort_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_outputs", {60'd0, in_ready, out_valid, busy, 1'b0}, 64'b1000);
    check("abort_data", out_data, 64'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;
    run_req("post_abort", 64'h0123456789ABCDEF, 2'b10, 2'd1, 64'h0011223344556677, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
